// File: rtl/dwt_block_ctrl.sv
// Block sequencer for the 8x8 2D DWT core: gathers 8 input rows, holds them on the
// core for its fixed latency, captures the 8 result rows and streams them downstream.
module dwt_block_ctrl #(
    parameter int ROW_W       = 64,
    parameter int DWT_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ROW_W-1:0] in_row,
    output logic [ROW_W-1:0] dwt_in1,
    output logic [ROW_W-1:0] dwt_in2,
    output logic [ROW_W-1:0] dwt_in3,
    output logic [ROW_W-1:0] dwt_in4,
    output logic [ROW_W-1:0] dwt_in5,
    output logic [ROW_W-1:0] dwt_in6,
    output logic [ROW_W-1:0] dwt_in7,
    output logic [ROW_W-1:0] dwt_in8,
    input  logic [ROW_W-1:0] dwt_out1,
    input  logic [ROW_W-1:0] dwt_out2,
    input  logic [ROW_W-1:0] dwt_out3,
    input  logic [ROW_W-1:0] dwt_out4,
    input  logic [ROW_W-1:0] dwt_out5,
    input  logic [ROW_W-1:0] dwt_out6,
    input  logic [ROW_W-1:0] dwt_out7,
    input  logic [ROW_W-1:0] dwt_out8,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_row,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] blk_count
);

    typedef enum logic [1:0] {LOAD, WAIT, DRAIN} state_t;

    localparam int WAIT_W = (DWT_LATENCY > 1) ? $clog2(DWT_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DWT_LATENCY - 1);

    // Handshakes: a row moves only on a cycle where both valid and ready are high at the
    // rising edge; the source holds its data until then and ready never depends on valid.
    state_t           state, state_next;
    logic [2:0]       row_cnt, out_cnt, out_cnt_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [ROW_W-1:0] din  [8];
    logic [ROW_W-1:0] obuf [8];
    logic             in_fire, out_fire, wait_done;

    assign dwt_in1 = din[0];
    assign dwt_in2 = din[1];
    assign dwt_in3 = din[2];
    assign dwt_in4 = din[3];
    assign dwt_in5 = din[4];
    assign dwt_in6 = din[5];
    assign dwt_in7 = din[6];
    assign dwt_in8 = din[7];

    assign out_cnt_next = out_cnt + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        in_fire    = 1'b0;
        out_fire   = 1'b0;
        wait_done  = 1'b0;
        case (state)
            LOAD: begin
                in_ready = !rst;
                in_fire  = in_valid && !rst;
                if (in_fire && row_cnt == 3'd7) state_next = WAIT;
            end
            WAIT: begin
                busy      = 1'b1;
                wait_done = (wait_cnt == WAIT_LAST);
                if (wait_done) state_next = DRAIN;
            end
            DRAIN: begin
                busy     = 1'b1;
                out_fire = out_valid && out_ready;
                if (out_fire && out_last) state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt   <= '0;
            wait_cnt  <= '0;
            out_cnt   <= '0;
            out_row   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            blk_count <= '0;
            for (int i = 0; i < 8; i++) begin
                din[i]  <= '0;
                obuf[i] <= '0;
            end
        end else begin
            // row_cnt wraps 7 -> 0 on the eighth accept, ready for the next block
            if (in_fire) begin
                din[row_cnt] <= in_row;
                row_cnt      <= row_cnt + 3'd1;
                if (row_cnt == 3'd7) wait_cnt <= '0;
            end
            if (state == WAIT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
                if (wait_done) begin
                    obuf[0]   <= dwt_out1;
                    obuf[1]   <= dwt_out2;
                    obuf[2]   <= dwt_out3;
                    obuf[3]   <= dwt_out4;
                    obuf[4]   <= dwt_out5;
                    obuf[5]   <= dwt_out6;
                    obuf[6]   <= dwt_out7;
                    obuf[7]   <= dwt_out8;
                    out_cnt   <= '0;
                    out_row   <= dwt_out1;
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                end
            end
            // Present the next buffered row straight from obuf so out_row stays a register
            if (out_fire) begin
                out_cnt <= out_cnt_next;
                if (out_last) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    blk_count <= blk_count + CNT_W'(1);
                end else begin
                    out_row  <= obuf[out_cnt_next];
                    out_last <= (out_cnt == 3'd6);
                end
            end
        end
    end

endmodule

// File: tb/tb_dwt_block_ctrl.sv
// Directed bench for dwt_block_ctrl: a table of whole-block scenarios plus hand-written
// reset sequences, with an identity delay-line model standing in for the DWT core.
module tb_dwt_block_ctrl;

    localparam int ROW_W = 64;
    localparam int LAT   = 4;
    localparam int CNT_W = 2;
    localparam logic [63:0] DEAD = 64'hDEAD_DEAD_DEAD_DEAD;

    logic clk, rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [ROW_W-1:0] in_row, out_row;
    logic [ROW_W-1:0] dwt_in1, dwt_in2, dwt_in3, dwt_in4, dwt_in5, dwt_in6, dwt_in7, dwt_in8;
    logic [ROW_W-1:0] dwt_out1, dwt_out2, dwt_out3, dwt_out4, dwt_out5, dwt_out6, dwt_out7, dwt_out8;
    logic [CNT_W-1:0] blk_count;

    int checks = 0;
    int errors = 0;
    logic [ROW_W-1:0] exp_q[$];

    typedef struct {
        logic [63:0]      base;
        bit               gaps;
        int               stall_row;
        int               stall_len;
        bit               dead;
        int               rst_at;
        logic [CNT_W-1:0] exp_cnt;
    } blk_vec_t;

    dwt_block_ctrl #(.ROW_W(ROW_W), .DWT_LATENCY(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .dwt_in1(dwt_in1), .dwt_in2(dwt_in2), .dwt_in3(dwt_in3), .dwt_in4(dwt_in4),
        .dwt_in5(dwt_in5), .dwt_in6(dwt_in6), .dwt_in7(dwt_in7), .dwt_in8(dwt_in8),
        .dwt_out1(dwt_out1), .dwt_out2(dwt_out2), .dwt_out3(dwt_out3), .dwt_out4(dwt_out4),
        .dwt_out5(dwt_out5), .dwt_out6(dwt_out6), .dwt_out7(dwt_out7), .dwt_out8(dwt_out8),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_last(out_last),
        .busy(busy), .blk_count(blk_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: identity, result valid once inputs have been stable for LAT edges
    logic [ROW_W-1:0] pipe [LAT-1][8];
    always @(posedge clk) begin
        for (int s = 1; s < LAT - 1; s++) pipe[s] <= pipe[s-1];
        pipe[0][0] <= dwt_in1; pipe[0][1] <= dwt_in2; pipe[0][2] <= dwt_in3; pipe[0][3] <= dwt_in4;
        pipe[0][4] <= dwt_in5; pipe[0][5] <= dwt_in6; pipe[0][6] <= dwt_in7; pipe[0][7] <= dwt_in8;
    end
    assign dwt_out1 = pipe[LAT-2][0];
    assign dwt_out2 = pipe[LAT-2][1];
    assign dwt_out3 = pipe[LAT-2][2];
    assign dwt_out4 = pipe[LAT-2][3];
    assign dwt_out5 = pipe[LAT-2][4];
    assign dwt_out6 = pipe[LAT-2][5];
    assign dwt_out7 = pipe[LAT-2][6];
    assign dwt_out8 = pipe[LAT-2][7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] dwt_in_k(input int k);
        case (k)
            0: return dwt_in1;  1: return dwt_in2;  2: return dwt_in3;  3: return dwt_in4;
            4: return dwt_in5;  5: return dwt_in6;  6: return dwt_in7;  default: return dwt_in8;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver tasks: inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_out_last"}, {63'd0, out_last}, 64'd0);
        check({tag, "_out_row"}, out_row, 64'd0);
        check({tag, "_blk_count"}, 64'(blk_count), 64'd0);
        for (int k = 0; k < 8; k++) check({tag, "_dwt_in"}, dwt_in_k(k), 64'd0);
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step();
        check_reset_outputs(tag);
        rst = 1'b0;
        #1;
        check({tag, "_in_ready_after"}, {63'd0, in_ready}, 64'd1);
        exp_q.delete();
    endtask

    task automatic feed_row(input logic [63:0] r);
        in_valid = 1'b1; in_row = r;
        check("in_ready_load", {63'd0, in_ready}, 64'd1);
        step();
        exp_q.push_back(r);
    endtask

    task automatic run_block(input blk_vec_t v);
        logic [63:0] rows [8];
        logic [63:0] snap;
        int cyc, idx, stalled;
        for (int i = 0; i < 8; i++) rows[i] = v.base * 64'(i + 1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (v.gaps) begin
                snap = dwt_in_k(i);
                in_valid = 1'b0; in_row = DEAD;
                step();
                check("gap_hold", dwt_in_k(i), snap);
            end
            feed_row(rows[i]);
        end
        in_valid = v.dead; in_row = DEAD;
        check("wait_busy", {63'd0, busy}, 64'd1);
        check("wait_in_ready", {63'd0, in_ready}, 64'd0);
        for (int k = 0; k < 8; k++) check("dwt_in_loaded", dwt_in_k(k), rows[k]);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        check("first_valid_latency", 64'(cyc), 64'(LAT));
        idx = 0; stalled = 0; cyc = 0;
        while (idx < 8 && cyc < 100) begin
            if (v.rst_at == idx) begin
                apply_reset("drain_rst");
                return;
            end
            check("drain_out_valid", {63'd0, out_valid}, 64'd1);
            check("drain_in_ready", {63'd0, in_ready}, 64'd0);
            check("drain_busy", {63'd0, busy}, 64'd1);
            if (exp_q.size() > 0) check("out_row", out_row, exp_q[0]);
            check("out_last", {63'd0, out_last}, {63'd0, idx == 7});
            if (idx == v.stall_row && stalled < v.stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
            end
            if (out_ready) begin
                void'(exp_q.pop_front());
                idx++;
            end
            if (idx == 8) in_valid = 1'b0;
            step();
            cyc++;
        end
        check("drain_rows", 64'(idx), 64'd8);
        out_ready = 1'b0;
        check("done_out_valid", {63'd0, out_valid}, 64'd0);
        check("done_in_ready", {63'd0, in_ready}, 64'd1);
        check("done_busy", {63'd0, busy}, 64'd0);
        check("done_blk_count", 64'(blk_count), 64'(v.exp_cnt));
        check("done_dwt_in1", dwt_in1, rows[0]);
        check("done_dwt_in8", dwt_in8, rows[7]);
    endtask

    // Test body
    initial begin
        blk_vec_t vecs [5];
        blk_vec_t hv;
        vecs[0] = '{64'h0101_0101_0101_0101, 1'b0, -1, 0, 1'b0, -1, 2'd1};
        vecs[1] = '{64'h1010_1010_1010_1010, 1'b1, -1, 0, 1'b0, -1, 2'd2};
        vecs[2] = '{64'h0303_0303_0303_0303, 1'b0,  3, 5, 1'b0, -1, 2'd3};
        vecs[3] = '{64'h0102_0304_0506_0708, 1'b0, -1, 0, 1'b1, -1, 2'd0};
        vecs[4] = '{64'h0011_0022_0033_0044, 1'b1,  3, 5, 1'b1, -1, 2'd1};

        rst = 1'b1; in_valid = 1'b0; in_row = '0; out_ready = 1'b0;
        step();
        apply_reset("por");

        for (int n = 0; n < 5; n++) run_block(vecs[n]);

        // Reset with a partial block loaded
        for (int i = 0; i < 5; i++) feed_row(64'h0F0F_0F0F_0F0F_0F0F + 64'(i));
        apply_reset("load_rst");
        hv = '{64'h0101_0101_0101_0101, 1'b0, -1, 0, 1'b0, -1, 2'd1};
        run_block(hv);

        // Reset during DRAIN with out_cnt==2, then recover
        hv = '{64'h0202_0202_0202_0202, 1'b0, -1, 0, 1'b1, 2, 2'd0};
        run_block(hv);
        hv = '{64'h0404_0404_0404_0404, 1'b0, -1, 0, 1'b0, -1, 2'd1};
        run_block(hv);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dwt_block_ctrl.md
Name: dwt_block_ctrl

Overview:
- Sequencer for the 8x8 2D DWT core (8 row inputs, 8 row outputs, 64 bits each, fixed pipeline latency, no valid/handshake of its own).
- Upstream side: accepts one 64-bit image row per cycle over a valid/ready handshake and assembles a full 8-row block.
- Core side: holds the block stable on the core inputs for the core's latency, then captures the 8 core outputs.
- Downstream side: streams the 8 coefficient rows out one per cycle with backpressure.
- Non-overlapped: one block in flight at a time.

Parameters:
- ROW_W, 64, bits per row (8 pixels x 8 bits).
- DWT_LATENCY, 4, core cycles from stable inputs to valid outputs (>=1).
- CNT_W, 16, width of completed-block counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream row valid.
- in_ready  out  1  controller accepts row.
- in_row  in  ROW_W  upstream row data, row 0 first.
- dwt_in1..dwt_in8  out  ROW_W each  registered rows 0..7 to core inputs.
- dwt_out1..dwt_out8  in  ROW_W each  core outputs.
- out_valid  out  1  output row valid.
- out_ready  in  1  downstream accepts row.
- out_row  out  ROW_W  coefficient row, dwt_out1 first.
- out_last  out  1  high with the 8th output row.
- busy  out  1  high in WAIT or DRAIN.
- blk_count  out  CNT_W  completed blocks, wraps to 0 after 2^CNT_W-1.

Behaviour:
- Reset (rst=1 at edge):
  - state<=LOAD; row_cnt, wait_cnt, out_cnt <= 0.
  - All dwt_inN, output buffer, out_row, blk_count <= 0.
  - out_valid, out_last, busy <= 0.
  - in_ready is 0 while rst is asserted, 1 on the first cycle after.
  - Reset mid-operation discards any partial or in-flight block; no output is produced for it.
- LOAD: in_ready=1.
  - Each in_valid&in_ready writes in_row into dwt_in[row_cnt+1] and increments row_cnt.
  - On the 8th accept (row_cnt==7): row_cnt<=0, wait_cnt<=0, state<=WAIT.
  - Cycles with in_valid=0 leave all state unchanged.
- WAIT: in_ready=0, busy=1; dwt_inN held constant.
  - wait_cnt increments each cycle.
  - When wait_cnt==DWT_LATENCY-1: capture dwt_out1..8 into obuf[0..7], out_cnt<=0, state<=DRAIN.
- DRAIN: in_ready=0, busy=1, out_valid=1, out_row=obuf[out_cnt], out_last=(out_cnt==7). out_row/out_valid/out_last are registered and glitch-free.
  - On out_valid&out_ready: out_cnt increments.
  - If the accepted row was the last: blk_count increments, state<=LOAD, out_valid<=0 next cycle.
  - out_ready=0 stalls indefinitely; out_row is held stable while stalled.
- Timing:
  - The 8th input row is accepted at edge T; WAIT is entered at T.
  - Capture occurs at edge T+DWT_LATENCY.
  - out_valid is first high in the cycle after T+DWT_LATENCY.
  - With out_ready constantly 1, out_last is accepted 7 cycles later, and in_ready is high again in the following cycle.
- in_valid asserted outside LOAD is ignored (in_ready=0); the upstream row must be held by the source.
- dwt_inN changes only in LOAD, so the core inputs are stable for the full WAIT window.
- No arithmetic on data; pure routing. Counters wrap modulo their width.

Test Plan:
- Core model = delay line of DWT_LATENCY cycles, identity transform.
- Basic block:
  - Stimulus: reset, then feed rows 64'h0101..01 through 64'h0808..08 back-to-back, out_ready=1.
  - Required: dwt_in1=0x01.., dwt_in8=0x08..; out_valid first high 4 cycles after the 8th accept; rows out in order 0x01..0x08; out_last only on 0x08; blk_count=1; in_ready high the next cycle.
- Input gaps:
  - Stimulus: in_valid toggling 1,0,1,0.
  - Required: exactly 8 accepts before WAIT; dwt_in unchanged on idle cycles; output identical to the basic-block case.
- Output backpressure:
  - Stimulus: out_ready low for 5 cycles on row 3.
  - Required: out_row holds row 3 and out_valid stays high; no row is skipped or duplicated; in_ready stays 0 until out_last is accepted.
- Ignored input:
  - Stimulus: in_valid=1 with in_row=0xDEAD.. during WAIT and DRAIN.
  - Required: in_ready=0; the next block's row 0 is whatever is presented after returning to LOAD; 0xDEAD never appears on dwt_in.
- Mid-operation reset:
  - Stimulus: assert rst after 5 rows loaded, and separately during DRAIN at out_cnt=2.
  - Required: all outputs 0 next cycle; blk_count=0; a new full block then processes correctly.
- Counter wrap:
  - Stimulus: CNT_W=2, run 5 blocks.
  - Required: blk_count sequence 1,2,3,0,1.
